frame_read_scheduler: RTL

//  Owns the SDRAM frame-buffer read port (RD1/RD2 of the 4-port SDRAM controller) and the camera start/stop.

---
 rtl/frame_read_scheduler_pkg.sv | 18 +
 rtl/frame_read_scheduler_sync2_bit.sv | 22 ++
 rtl/frame_read_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/frame_read_scheduler_pkg.sv
// Shared definitions for the frame-buffer read scheduler: state encoding
// (also the oSTATE readout value) and default frame geometry.
package frame_read_scheduler_pkg;

   localparam int FRAME_PIXELS_DEF = 307200;   // 640*480
   localparam int PIX_W_DEF        = 10;       // grayscale pixel width
   localparam int STATE_W          = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LIVE  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FLUSH = 3'd3,
      ST_HPS   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/frame_read_scheduler_sync2_bit.sv
// Two-flop synchronizer for a single asynchronous level into the iCLK domain.
module sync2_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the async level through two flops to settle metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/frame_read_scheduler.sv
// Frame-buffer read sequencer: owns the SDRAM read port and camera start/stop.
// LIVE passes VGA requests straight through; stop mode drains the camera frame,
// flushes the read FIFOs and then serves the HPS one pixel per req/ack handshake.
module frame_read_scheduler
   import frame_read_scheduler_pkg::*;
#(
   parameter int FRAME_PIXELS  = FRAME_PIXELS_DEF,
   parameter int PIX_W         = PIX_W_DEF,
   parameter int LOAD_CYCLES   = 4,
   parameter int RD_LAT        = 2,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             iCAM_RUN,
   input  logic             iCCD_FVAL,
   input  logic             iVGA_REQ,
   input  logic             iVGA_VS_N,
   input  logic             iHPS_REQ,
   input  logic [PIX_W-1:0] iRD_DATA,
   output logic             oRD_REQ,
   output logic             oRD_LOAD,
   output logic             oCAM_START,
   output logic             oCAM_END,
   output logic             oHPS_ACK,
   output logic [PIX_W-1:0] oHPS_PIXEL,
   output logic             oHPS_DONE,
   output logic [2:0]       oSTATE
);

   localparam int CNT_W  = $clog2(FRAME_PIXELS + 1);
   localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
   localparam int LOAD_W = $clog2(LOAD_CYCLES + 1);
   localparam int LAT_W  = $clog2(RD_LAT + 2);

   state_t             state;
   logic               run_s, fval_s, req_s;
   logic               run_q, req_q, vs_q;
   logic               run_rise, req_rise, vs_fall;
   logic               rd_pulse;
   logic [CNT_W-1:0]   pix_cnt;
   logic [SET_W-1:0]   settle_cnt;
   logic [LOAD_W-1:0]  load_cnt;
   logic [LAT_W-1:0]   lat_cnt;     // 0 = no read in flight, else cycles since the read strobe

   sync2_bit u_sync_run  (.clk(iCLK), .rst_n(iRST_N), .d(iCAM_RUN),  .q(run_s));
   sync2_bit u_sync_fval (.clk(iCLK), .rst_n(iRST_N), .d(iCCD_FVAL), .q(fval_s));
   sync2_bit u_sync_req  (.clk(iCLK), .rst_n(iRST_N), .d(iHPS_REQ),  .q(req_s));

   // Delayed copies of the synced levels and VS_N for edge detection
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         run_q <= 1'b0;
         req_q <= 1'b0;
         vs_q  <= 1'b0;
      end else begin
         run_q <= run_s;
         req_q <= req_s;
         vs_q  <= iVGA_VS_N;
      end
   end

   assign run_rise = run_s & ~run_q;
   assign req_rise = req_s & ~req_q;
   assign vs_fall  = vs_q & ~iVGA_VS_N;

   // VGA requests bypass the sequencer in LIVE; elsewhere only the HPS read strobe drives the FIFOs
   assign oRD_REQ = (state == ST_LIVE) ? iVGA_REQ : rd_pulse;
   assign oSTATE  = state;

   // Main sequencer: mode FSM, drain/flush timing and the HPS pixel handshake
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state      <= ST_IDLE;
         oCAM_START <= 1'b0;
         oCAM_END   <= 1'b0;
         oRD_LOAD   <= 1'b0;
         rd_pulse   <= 1'b0;
         oHPS_ACK   <= 1'b0;
         oHPS_PIXEL <= '0;
         oHPS_DONE  <= 1'b0;
         pix_cnt    <= '0;
         settle_cnt <= '0;
         load_cnt   <= '0;
         lat_cnt    <= '0;
      end else begin
         oCAM_START <= 1'b0;
         oCAM_END   <= 1'b0;
         oRD_LOAD   <= 1'b0;
         rd_pulse   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run_rise) begin
                  oCAM_START <= 1'b1;
                  oRD_LOAD   <= 1'b1;
                  state      <= ST_LIVE;
               end
            end
            ST_LIVE: begin
               // frame realign still happens if the camera stops on the same cycle
               if (vs_fall)
                  oRD_LOAD <= 1'b1;
               if (!run_s) begin
                  oCAM_END   <= 1'b1;
                  settle_cnt <= '0;
                  state      <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // settle window restarts if FVAL comes back high
               if (fval_s) begin
                  settle_cnt <= '0;
               end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                  settle_cnt <= '0;
                  load_cnt   <= '0;
                  oRD_LOAD   <= 1'b1;
                  state      <= ST_FLUSH;
               end else begin
                  settle_cnt <= settle_cnt + SET_W'(1);
               end
            end
            ST_FLUSH: begin
               if (load_cnt == LOAD_W'(LOAD_CYCLES - 1)) begin
                  pix_cnt   <= '0;
                  oHPS_DONE <= 1'b0;
                  lat_cnt   <= '0;
                  state     <= ST_HPS;
               end else begin
                  load_cnt <= load_cnt + LOAD_W'(1);
                  oRD_LOAD <= 1'b1;
               end
            end
            ST_HPS: begin
               if (lat_cnt != '0) begin
                  if (lat_cnt == LAT_W'(RD_LAT)) begin
                     oHPS_PIXEL <= iRD_DATA;
                     lat_cnt    <= lat_cnt + LAT_W'(1);
                  end else if (lat_cnt == LAT_W'(RD_LAT + 1)) begin
                     oHPS_ACK <= 1'b1;
                     pix_cnt  <= pix_cnt + CNT_W'(1);
                     lat_cnt  <= '0;
                  end else begin
                     lat_cnt <= lat_cnt + LAT_W'(1);
                  end
               end else if (oHPS_ACK) begin
                  if (!req_s) begin
                     oHPS_ACK <= 1'b0;
                     if (pix_cnt == CNT_W'(FRAME_PIXELS)) begin
                        oHPS_DONE <= 1'b1;
                        state     <= ST_DONE;
                     end
                  end
               end else if (run_s && !req_s) begin
                  // camera restart waits for an idle handshake
                  oCAM_START <= 1'b1;
                  oRD_LOAD   <= 1'b1;
                  state      <= ST_LIVE;
               end else if (req_rise) begin
                  rd_pulse <= 1'b1;
                  lat_cnt  <= LAT_W'(1);
               end
            end
            ST_DONE: begin
               // frame already delivered: acknowledge with a zero pixel, no FIFO read
               if (oHPS_ACK) begin
                  if (!req_s)
                     oHPS_ACK <= 1'b0;
               end else if (run_s && !req_s) begin
                  oCAM_START <= 1'b1;
                  oRD_LOAD   <= 1'b1;
                  state      <= ST_LIVE;
               end else if (req_rise) begin
                  oHPS_ACK   <= 1'b1;
                  oHPS_PIXEL <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
